// File: rtl/motoro3_line_pwm_gen.sv
// Line PWM generator: turns latched line parameters into a PWM waveform whose duty
// ramps linearly per period across a segment, with a step index advanced per segment.
module motoro3_line_pwm_gen #(
    parameter int unsigned SEG_PERIODS = 16,
    parameter int unsigned CONST_FRAC  = 8
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        enable,
    input  logic [7:0]  pwmLen,
    input  logic [7:0]  pwmMin,
    input  logic [3:0]  lcStep,
    input  logic [15:0] lcConst,
    output logic        pwmOut,
    output logic        periodStart,
    output logic        segDone,
    output logic [7:0]  dutyNow,
    output logic [3:0]  stepNow,
    output logic        busy,
    output logic        paramErr
);

    localparam int unsigned ACC_W   = 8 + CONST_FRAC + 1;
    localparam int unsigned SUM_W   = ACC_W + 1;
    localparam int unsigned WHOLE_W = ACC_W - CONST_FRAC;
    localparam int unsigned PER_W   = 8;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, STOP} state_t;

    state_t             state, nxt_state;
    logic [7:0]         tick, nxt_tick;
    logic [PER_W-1:0]   per, nxt_per;
    logic [ACC_W-1:0]   acc, nxt_acc;
    logic [7:0]         len_l, nxt_len;
    logic [15:0]        const_l, nxt_const;
    logic [3:0]         nxt_step;
    logic [7:0]         nxt_duty;
    logic [SUM_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   acc_sat;
    logic [ACC_W-1:0]   min_acc;
    logic               last_tick;
    logic               last_per;

    // Integer part of the accumulator, clamped to the period length.
    function automatic logic [7:0] clamp_duty(input logic [ACC_W-1:0] a, input logic [7:0] len);
        logic [WHOLE_W-1:0] whole;
        whole = a[ACC_W-1:CONST_FRAC];
        if (whole > WHOLE_W'(len)) begin
            return len;
        end
        return 8'(whole);
    endfunction

    assign acc_sum   = SUM_W'(acc) + SUM_W'(const_l);
    assign acc_sat   = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    assign min_acc   = ACC_W'(pwmMin) << CONST_FRAC;
    assign last_tick = (tick == len_l - 8'd1);
    assign last_per  = (per == PER_W'(SEG_PERIODS - 1));
    assign paramErr  = (state == IDLE) && enable && (pwmLen == 8'd0);

    // Next-state and next-counter decode.
    always_comb begin
        nxt_state = state;
        nxt_tick  = tick;
        nxt_per   = per;
        nxt_acc   = acc;
        nxt_len   = len_l;
        nxt_const = const_l;
        nxt_step  = stepNow;
        nxt_duty  = dutyNow;
        case (state)
            IDLE: begin
                if (enable && (pwmLen != 8'd0)) begin
                    nxt_state = LOAD;
                    nxt_len   = pwmLen;
                    nxt_const = lcConst;
                    nxt_acc   = min_acc;
                    nxt_step  = lcStep;
                    nxt_tick  = 8'd0;
                    nxt_per   = '0;
                end
            end
            LOAD: begin
                nxt_state = RUN;
                nxt_tick  = 8'd0;
                nxt_per   = '0;
                nxt_duty  = clamp_duty(acc, len_l);
            end
            RUN: begin
                if (!last_tick) begin
                    nxt_tick = tick + 8'd1;
                end else begin
                    nxt_tick = 8'd0;
                    if (last_per) begin
                        nxt_step = stepNow + 4'd1;
                        nxt_per  = '0;
                        // Back-to-back segment: parameters re-latched with no gap cycle.
                        if (enable && (pwmLen != 8'd0)) begin
                            nxt_len   = pwmLen;
                            nxt_const = lcConst;
                            nxt_acc   = min_acc;
                            nxt_duty  = clamp_duty(min_acc, pwmLen);
                        end else begin
                            nxt_state = STOP;
                        end
                    end else begin
                        nxt_acc = acc_sat;
                        nxt_per = per + PER_W'(1);
                        if (enable) begin
                            nxt_duty = clamp_duty(acc_sat, len_l);
                        end else begin
                            nxt_state = STOP;
                        end
                    end
                end
            end
            STOP: nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // State, counters and outputs registered from the next-cycle view.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= IDLE;
            tick        <= 8'd0;
            per         <= '0;
            acc         <= '0;
            len_l       <= 8'd0;
            const_l     <= 16'd0;
            pwmOut      <= 1'b0;
            periodStart <= 1'b0;
            segDone     <= 1'b0;
            dutyNow     <= 8'd0;
            stepNow     <= 4'd0;
            busy        <= 1'b0;
        end else begin
            state       <= nxt_state;
            tick        <= nxt_tick;
            per         <= nxt_per;
            acc         <= nxt_acc;
            len_l       <= nxt_len;
            const_l     <= nxt_const;
            dutyNow     <= nxt_duty;
            stepNow     <= nxt_step;
            busy        <= (nxt_state == LOAD) || (nxt_state == RUN);
            pwmOut      <= (nxt_state == RUN) && (nxt_tick < nxt_duty);
            periodStart <= (nxt_state == RUN) && (nxt_tick == 8'd0);
            segDone     <= (nxt_state == RUN) && (nxt_tick == nxt_len - 8'd1) &&
                           (nxt_per == PER_W'(SEG_PERIODS - 1));
        end
    end

endmodule

// File: tb/tb_motoro3_line_pwm_gen.sv
// Scoreboard bench for motoro3_line_pwm_gen: expected per-cycle output words are
// queued from a behavioural model when a run starts and popped each cycle.
module tb_motoro3_line_pwm_gen;

    localparam int SEG     = 4;
    localparam int FRAC    = 8;
    localparam int ACC_MAX = (1 << (8 + FRAC + 1)) - 1;

    logic        clk;
    logic        nRst;
    logic        enable;
    logic [7:0]  pwmLen;
    logic [7:0]  pwmMin;
    logic [3:0]  lcStep;
    logic [15:0] lcConst;
    logic        pwmOut;
    logic        periodStart;
    logic        segDone;
    logic [7:0]  dutyNow;
    logic [3:0]  stepNow;
    logic        busy;
    logic        paramErr;

    int n_cmp;
    int n_err;
    int exp_q[$];
    int last_duty;

    motoro3_line_pwm_gen #(.SEG_PERIODS(SEG), .CONST_FRAC(FRAC)) dut (
        .clk(clk), .nRst(nRst), .enable(enable), .pwmLen(pwmLen), .pwmMin(pwmMin),
        .lcStep(lcStep), .lcConst(lcConst), .pwmOut(pwmOut), .periodStart(periodStart),
        .segDone(segDone), .dutyNow(dutyNow), .stepNow(stepNow), .busy(busy),
        .paramErr(paramErr)
    );

    always #5 clk = ~clk;

    function automatic int pack(input int pwm, input int ps, input int sd, input int bsy,
                                input int perr, input int duty, input int step);
        return (pwm << 16) | (ps << 15) | (sd << 14) | (bsy << 13) | (perr << 12) |
               ((duty & 255) << 4) | (step & 15);
    endfunction

    function automatic int observed();
        return pack(int'(pwmOut), int'(periodStart), int'(segDone), int'(busy),
                    int'(paramErr), int'(dutyNow), int'(stepNow));
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
        end
    endtask

    // Model of a run of nper PWM periods ending with enable dropped, then STOP and IDLE.
    task automatic push_expect(input int len, input int mn, input int cst, input int step,
                               input int nper);
        int acc, duty, stp;
        stp = step;
        exp_q.push_back(pack(0, 0, 0, 1, 0, last_duty, stp));
        acc = 0;
        for (int p = 0; p < nper; p++) begin
            if (p % SEG == 0) acc = mn << FRAC;
            duty = acc >> FRAC;
            if (duty > len) duty = len;
            for (int t = 0; t < len; t++) begin
                exp_q.push_back(pack((t < duty) ? 1 : 0, (t == 0) ? 1 : 0,
                                     (t == len - 1 && p % SEG == SEG - 1) ? 1 : 0,
                                     1, 0, duty, stp));
            end
            acc = acc + cst;
            if (acc > ACC_MAX) acc = ACC_MAX;
            if (p % SEG == SEG - 1) stp = (stp + 1) % 16;
            last_duty = duty;
        end
        exp_q.push_back(pack(0, 0, 0, 0, 0, last_duty, stp));
        exp_q.push_back(pack(0, 0, 0, 0, 0, last_duty, stp));
    endtask

    // Start a run at a negedge and compare each cycle; enable drops after drop_after words.
    task automatic run_case(input string tag, input int len, input int mn, input int cst,
                            input int step, input int nper, input int drop_after,
                            input bit scramble);
        int cnt;
        cnt = 0;
        pwmLen  = 8'(len);
        pwmMin  = 8'(mn);
        lcConst = 16'(cst);
        lcStep  = 4'(step);
        enable  = 1'b1;
        push_expect(len, mn, cst, step, nper);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cnt++;
            check($sformatf("%s[%0d]", tag, cnt), observed(), exp_q.pop_front());
            if (cnt == drop_after) enable = 1'b0;
            if (scramble && cnt == 3) begin
                pwmLen  = 8'd3;
                pwmMin  = 8'd0;
                lcConst = 16'h0400;
                lcStep  = 4'd11;
            end
        end
    endtask

    initial begin
        clk = 1'b0; nRst = 1'b0; enable = 1'b0;
        pwmLen = 8'd0; pwmMin = 8'd0; lcStep = 4'd0; lcConst = 16'd0;
        n_cmp = 0; n_err = 0; last_duty = 0;

        repeat (2) @(negedge clk);
        check("reset", observed(), 0);
        nRst = 1'b1;
        @(negedge clk);
        check("idle_after_reset", observed(), 0);

        // Linear ramp 3,4,5,6 with parameter changes mid-run ignored.
        run_case("ramp", 10, 3, 16'h0100, 2, SEG, 1 + SEG * 10, 1'b1);
        // Fractional slope with clamp at pwmLen.
        run_case("clamp", 8, 6, 16'h0180, 0, SEG, 1 + SEG * 8, 1'b0);
        // Step wrap 15->0->1 over two back-to-back segments.
        run_case("wrap", 5, 1, 16'h0080, 15, 2 * SEG, 1 + 2 * SEG * 5, 1'b0);
        // Accumulator saturation keeps duty at the clamp.
        run_case("sat", 250, 200, 16'hFFFF, 7, SEG, 1 + SEG * 250, 1'b0);
        // pwmMin above pwmLen: output high for the whole period.
        run_case("full", 4, 9, 16'h0000, 3, SEG, 1 + SEG * 4, 1'b0);
        // Enable dropped at tick 2 of period 1: period completes, no segDone.
        run_case("drop", 6, 2, 16'h0100, 5, 2, 1 + 6 + 3, 1'b0);

        // Zero period length while enabled is flagged and does not start.
        @(negedge clk);
        pwmLen = 8'd0; enable = 1'b1;
        #1 check("perr_comb", int'(paramErr), 1);
        @(negedge clk);
        check("perr_idle", observed(), pack(0, 0, 0, 0, 1, last_duty, 5));
        pwmLen = 8'd5;
        #1 check("perr_clear", int'(paramErr), 0);
        run_case("zero_duty", 5, 0, 16'h0000, 9, 1, 1 + 5, 1'b0);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        pwmLen = 8'd7; pwmMin = 8'd4; lcConst = 16'h0100; lcStep = 4'd6; enable = 1'b1;
        repeat (5) @(negedge clk);
        nRst = 1'b0;
        #1 check("reset_mid_run", observed(), 0);
        enable = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_mid_reset", observed(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/motoro3_line_pwm_gen.md
Name: motoro3_line_pwm_gen

Overview:
Consumes the line parameters (pwmLen, pwmMin, lcStep) and the 16-bit sine-length constant produced by the line calc/sine-len path. Turns them into a running 3-phase-line PWM waveform: a duty that ramps linearly per PWM period across a line segment, and a step index that advances once per segment. Sits between the parameter calculator and the phase output driver.

Parameters:
SEG_PERIODS, 16, PWM periods per line segment (2..256).
CONST_FRAC, 8, fractional bits of lcConst slope (duty increment = lcConst / 2^CONST_FRAC per period).

Ports:
clk  input  1  system clock
nRst  input  1  asynchronous active-low reset
enable  input  1  run request, level
pwmLen  input  8  PWM period in clk ticks; 0 is invalid
pwmMin  input  8  starting duty of each segment, in ticks
lcStep  input  4  step index loaded at run start
lcConst  input  16  per-period duty slope, fixed point
pwmOut  output  1  PWM output
periodStart  output  1  one-cycle pulse, first tick of each PWM period
segDone  output  1  one-cycle pulse, last tick of each segment
dutyNow  output  8  duty in use for the current period
stepNow  output  4  current step index
busy  output  1  high in LOAD/RUN
paramErr  output  1  high while enable=1 and pwmLen=0 in IDLE

Behaviour:
- Reset (nRst low, async): state IDLE; all outputs 0; counters, accumulator, latched params cleared.
- States: IDLE, LOAD, RUN, STOP.
- IDLE: enable=1 and pwmLen!=0 -> LOAD next cycle. enable=1 and pwmLen=0 -> stay IDLE, paramErr=1 (combinational on those inputs while in IDLE).
- LOAD (1 cycle): latch pwmLen, lcConst; acc <= {pwmMin, CONST_FRAC zeros}; stepNow <= lcStep; tick=0, per=0. busy=1, pwmOut=0. -> RUN.
- RUN: tick counts 0..lenL-1. tick==0: periodStart=1, dutyNow <= min(acc>>CONST_FRAC, lenL) (registered at that edge, so pwmOut uses new duty from tick 0). pwmOut = (tick < dutyNow).
- End of period (tick==lenL-1): acc <= acc + lcConst, saturating at all-ones (acc width 8+CONST_FRAC+1 bits); per++.
- End of segment (tick==lenL-1 and per==SEG_PERIODS-1): segDone=1; stepNow++ wrapping 15->0; if enable=1, re-latch pwmLen/pwmMin/lcConst (acc reloads from new pwmMin, tick=0, per=0) and stay in RUN with no gap cycle; if new pwmLen=0 -> STOP.
- enable dropped mid-segment: current PWM period completes; at its last tick -> STOP (segDone not asserted unless it is also segment end).
- STOP (1 cycle): pwmOut=0, busy=0 -> IDLE. stepNow holds value.
- Input parameter changes during RUN ignored until next segment boundary.
- pwmMin >= pwmLen: duty clamps to pwmLen (100%, pwmOut constant 1 for the period).
- Duty = 0: pwmOut low for the whole period.
- Latency: enable rises at edge N -> LOAD at N+1 -> first periodStart and first pwmOut tick at N+2.

Test Plan:
- Reset mid-RUN: assert nRst low at an arbitrary tick -> all outputs 0 immediately, state IDLE after release.
- pwmLen=10, pwmMin=3, lcConst=0x0100, lcStep=2, SEG_PERIODS=4 -> dutyNow 3,4,5,6 in periods 0..3; pwmOut high ticks 3,4,5,6; segDone at tick 9 of period 3; stepNow 2->3.
- pwmLen=8, pwmMin=6, lcConst=0x0180 -> duties 6,7(7.5 floor),8 then clamp 8; pwmOut fully high when duty=8.
- lcStep=15 over two segments -> stepNow 15->0->1, wrap with no gap cycle between segments (periodStart on the tick after segDone).
- enable=1 with pwmLen=0 -> paramErr=1, busy=0, pwmOut=0. Then pwmLen=5 -> LOAD next cycle, paramErr=0.
- enable dropped at tick 2 of period 1, pwmLen=6 -> pwmOut continues through tick 5; STOP for 1 cycle; busy=0 two cycles after period end; no segDone.
